// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parameterised serial pattern detector:
// state-width sizing and the longest prefix-suffix match used for next-state.
package seq_detect_pkg;

  localparam int MAX_W   = 16;
  localparam int MAX_K_W = $clog2(MAX_W + 1);

  function automatic int state_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // hist holds accepted bits with the newest at index 0; pat is right-aligned
  // with its first expected bit at pat_w-1. Returns the largest j <= limit.
  function automatic int prefix_suffix_len(
    input logic [MAX_W-1:0] hist,
    input logic [MAX_W-1:0] pat,
    input int               pat_w,
    input int               limit
  );
    int               best;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] prefix;
    best = 0;
    for (int j = 1; j <= MAX_W; j++) begin
      if (j <= limit && j <= pat_w) begin
        mask   = {MAX_W{1'b1}} >> (MAX_W - j);
        prefix = pat >> (pat_w - j);
        if ((hist & mask) == (prefix & mask)) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the match count.
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (clear)
      value <= '0;
    else if (inc && value != {CNT_W{1'b1}})
      value <= value + CNT_W'(1);
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised Moore serial pattern detector with runtime-loadable pattern,
// optional overlap and a saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W    = 3,
  parameter logic [PAT_W-1:0] PAT_INIT = 3'b101,
  parameter bit               OVERLAP  = 1'b1,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] pattern_q
);
  import seq_detect_pkg::*;

  localparam int K_W = state_width(PAT_W);

  logic [K_W-1:0]   k;
  logic [K_W-1:0]   k_next;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic             enter_match;
  int               limit;

  // k is the matched-prefix length; without overlap a completed match
  // restarts the search as if nothing had been matched yet.
  always_comb begin
    k_next      = k;
    hist_next   = hist;
    enter_match = 1'b0;
    limit       = (int'(k) + 1 > PAT_W) ? PAT_W : int'(k) + 1;
    if (in_valid) begin
      hist_next = {hist[PAT_W-2:0], in};
      if (OVERLAP == 1'b0 && k == K_W'(PAT_W))
        k_next = (in == pattern_q[PAT_W-1]) ? K_W'(1) : '0;
      else
        k_next = K_W'(prefix_suffix_len(MAX_W'(hist_next), MAX_W'(pattern_q),
                                        PAT_W, limit));
      enter_match = (k_next == K_W'(PAT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      hist      <= '0;
      pattern_q <= PAT_INIT;
      out       <= 1'b0;
    end else if (cfg_we) begin
      k         <= '0;
      hist      <= '0;
      pattern_q <= cfg_pattern;
      out       <= 1'b0;
    end else begin
      k         <= k_next;
      hist      <= hist_next;
      out       <= (k_next == K_W'(PAT_W));
    end
  end

  // A bit arriving with cfg_we is discarded, so it can never count as a match.
  seq_sat_counter #(
    .CNT_W(CNT_W)
  ) u_count (
    .clk  (clk),
    .clear(reset),
    .inc  (enter_match && !cfg_we),
    .value(match_count)
  );

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_INIT, default 3'b101 (PAT_W bits): pattern loaded at reset.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in  input  1  serial data bit.
REQ-008 in_valid  input  1  qualifies in; when low, in is ignored for that cycle.
REQ-009 cfg_we  input  1  one-cycle strobe that loads cfg_pattern.
REQ-010 cfg_pattern  input  PAT_W  new pattern; the MSB is the first bit expected.
REQ-011 out  output  1  Moore match flag, high while the FSM is in the full-match state.
REQ-012 match_count  output  CNT_W  number of matches since reset, saturating.
REQ-013 pattern_q  output  PAT_W  currently active pattern.

Function
REQ-014 The FSM state SHALL be the matched-prefix length k, range 0..PAT_W, held in a register of clog2(PAT_W+1) bits.
REQ-015 On a cycle with in_valid=1, the next k SHALL be the largest j <= min(k+1, PAT_W) such that the last j accepted bits equal pattern_q[PAT_W-1 -: j]; j=0 if no such j exists.
REQ-016 When OVERLAP=1, leaving k=PAT_W SHALL use the REQ-015 rule, so a suffix of the completed match may be reused.
REQ-017 When OVERLAP=0, leaving k=PAT_W SHALL evaluate as if k=0: next k = (in==pattern_q[PAT_W-1]) ? 1 : 0.
REQ-018 A history shift register of PAT_W bits SHALL hold the accepted bits and shift only when in_valid=1.
REQ-019 When in_valid=0, k, the history register and match_count SHALL hold.
REQ-020 out SHALL equal (k==PAT_W); it is a registered-state Moore output with one cycle of latency from the completing bit.
REQ-021 match_count SHALL increment by 1 on every transition into k=PAT_W, including PAT_W->PAT_W under overlap, and SHALL saturate at 2^CNT_W-1.
REQ-022 On cfg_we=1, pattern_q SHALL load cfg_pattern, and k and the history register SHALL clear to 0 on the same edge.
REQ-023 On a cfg_we=1 cycle, any in_valid bit SHALL be discarded.
REQ-024 match_count SHALL NOT be cleared by cfg_we.
REQ-025 With PAT_W=3, PAT_INIT=3'b101 and OVERLAP=1, the block SHALL be cycle-equivalent to the team's existing 4-state A/B/C/D Moore detector: k=0/1/2/3 correspond to A/B/C/D.

Reset
REQ-026 Reset priority SHALL be reset > cfg_we > in_valid.
REQ-027 Reset SHALL set k=0, history=0, match_count=0, pattern_q=PAT_INIT and out=0 on the next rising edge.
REQ-028 Reset asserted mid-match SHALL discard all partial progress; detection SHALL restart from k=0 on the first cycle after reset deasserts.

Structure
REQ-029 A shared package seq_detect_pkg SHALL hold the function computing the longest prefix-suffix match used for next-state, and the clog2-based state-width localparam.
REQ-030 The block SHALL contain one sub-module, seq_sat_counter (parameter CNT_W; inc, clear, value), for match_count; the remainder is inline.
REQ-031 Next-state logic SHALL be one combinational always block; state, history and pattern_q SHALL update in one clocked block.

Verification
REQ-032 Defaults; in stream 1,0,1,0,1 with valid=1 -> out high on the cycles after bit 3 and bit 5; match_count=2.
REQ-033 OVERLAP=0, same stream 1,0,1,0,1 -> out high only after bit 3; match_count=1.
REQ-034 Defaults; stream 1,0, then valid=0 for 4 cycles, then 1 -> k holds at 2 during the gap; out=1 one cycle after the final bit.
REQ-035 cfg_we with cfg_pattern=3'b110 asserted mid-stream (k=2) -> k=0 next cycle; then stream 1,1,0 -> out=1 and match_count increments.
REQ-036 CNT_W=2, stream of twelve 1s with pattern 3'b111 and OVERLAP=1 -> match_count saturates at 3; out stays high from bit 3 onward.
REQ-037 Reset pulse while k=2 -> k=0, match_count=0, pattern_q=PAT_INIT next cycle; then bit 1 -> k=1 with no spurious match.
